// File: rtl/dcache_wb_dm.sv
// Direct-mapped, write-back, write-allocate data cache behind the MEM stage.
// 4-word blocks, one-cycle mem_ready handshake with a slow block memory.
module dcache_wb_dm #(
    parameter int INDEX_W = 3
) (
    input  logic         Clk,
    input  logic         rst_n,
    input  logic         proc_read,
    input  logic         proc_write,
    input  logic [29:0]  proc_addr,
    input  logic [31:0]  proc_wdata,
    output logic [31:0]  proc_rdata,
    output logic         proc_stall,
    output logic         mem_read,
    output logic         mem_write,
    output logic [27:0]  mem_addr,
    output logic [127:0] mem_wdata,
    input  logic [127:0] mem_rdata,
    input  logic         mem_ready
);

    localparam int TAG_W = 28 - INDEX_W;
    localparam int NBLK  = 1 << INDEX_W;

    typedef enum logic [1:0] {COMPARE, WRITEBACK, ALLOCATE} state_t;

    state_t state, state_nxt;

    logic [NBLK-1:0]  valid_q;
    logic [NBLK-1:0]  dirty_q;
    logic [TAG_W-1:0] tag_mem  [NBLK];
    logic [127:0]     data_mem [NBLK];

    logic [1:0]         off;
    logic [INDEX_W-1:0] idx;
    logic [TAG_W-1:0]   req_tag;
    logic               req;
    logic               hit;
    logic               store_en;
    logic               fill_en;
    logic               wb_done;

    assign off     = proc_addr[1:0];
    assign idx     = proc_addr[INDEX_W+1:2];
    assign req_tag = proc_addr[29:INDEX_W+2];
    assign req     = proc_read | proc_write;
    assign hit     = valid_q[idx] && (tag_mem[idx] == req_tag);

    always_comb begin
        state_nxt  = state;
        proc_stall = 1'b0;
        proc_rdata = '0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        store_en   = 1'b0;
        fill_en    = 1'b0;
        wb_done    = 1'b0;
        case (state)
            COMPARE: begin
                if (req) begin
                    if (hit) begin
                        if (proc_write) store_en = 1'b1;
                        else            proc_rdata = data_mem[idx][{off, 5'd0} +: 32];
                    end else begin
                        proc_stall = 1'b1;
                        state_nxt  = (valid_q[idx] && dirty_q[idx]) ? WRITEBACK : ALLOCATE;
                    end
                end
            end
            WRITEBACK: begin
                mem_write  = 1'b1;
                mem_addr   = {tag_mem[idx], idx};
                mem_wdata  = data_mem[idx];
                proc_stall = 1'b1;
                if (mem_ready) begin
                    wb_done = 1'b1;
                    // a request dropped mid-stall just finishes the write-back
                    state_nxt = req ? ALLOCATE : COMPARE;
                end
            end
            ALLOCATE: begin
                mem_read   = 1'b1;
                mem_addr   = {req_tag, idx};
                proc_stall = 1'b1;
                if (mem_ready) begin
                    fill_en   = 1'b1;
                    state_nxt = COMPARE;
                end
            end
            default: state_nxt = COMPARE;
        endcase
    end

    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= COMPARE;
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            state <= state_nxt;
            if (store_en) dirty_q[idx] <= 1'b1;
            if (wb_done)  dirty_q[idx] <= 1'b0;
            if (fill_en) begin
                valid_q[idx] <= 1'b1;
                dirty_q[idx] <= 1'b0;
            end
        end
    end

    // Tag and data arrays carry no reset; valid gates their use.
    always_ff @(posedge Clk) begin
        if (store_en) data_mem[idx][{off, 5'd0} +: 32] <= proc_wdata;
        if (fill_en) begin
            data_mem[idx] <= mem_rdata;
            tag_mem[idx]  <= req_tag;
        end
    end

endmodule

// File: tb/tb_dcache_wb_dm.sv
// Randomized bench for dcache_wb_dm against a word-level memory model with
// line bookkeeping that predicts hits, write-backs and stall counts.
module tb_dcache_wb_dm;

    logic         Clk;
    logic         rst_n;
    logic         proc_read;
    logic         proc_write;
    logic [29:0]  proc_addr;
    logic [31:0]  proc_wdata;
    logic [31:0]  proc_rdata;
    logic         proc_stall;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ready;

    dcache_wb_dm #(.INDEX_W(3)) dut (
        .Clk        (Clk),
        .rst_n      (rst_n),
        .proc_read  (proc_read),
        .proc_write (proc_write),
        .proc_addr  (proc_addr),
        .proc_wdata (proc_wdata),
        .proc_rdata (proc_rdata),
        .proc_stall (proc_stall),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Processor-visible word memory, the memory device contents, and line bookkeeping.
    logic [31:0]  ref_mem [logic [29:0]];
    logic [127:0] backing [logic [27:0]];
    bit           mv [8];
    bit           md [8];
    logic [24:0]  mt [8];

    function automatic logic [31:0] init_word(input logic [29:0] a);
        return {2'b00, a} ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] ref_word(input logic [29:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return init_word(a);
    endfunction

    function automatic logic [127:0] ref_block(input logic [27:0] ba);
        return {ref_word({ba, 2'd3}), ref_word({ba, 2'd2}), ref_word({ba, 2'd1}), ref_word({ba, 2'd0})};
    endfunction

    function automatic logic [127:0] mem_block(input logic [27:0] ba);
        if (backing.exists(ba)) return backing[ba];
        return {init_word({ba, 2'd3}), init_word({ba, 2'd2}), init_word({ba, 2'd1}), init_word({ba, 2'd0})};
    endfunction

    task automatic do_req(input bit wr, input logic [29:0] a, input logic [31:0] wd,
                          input int lat, output logic [31:0] rd, output int stalls);
        logic [2:0]   idx;
        logic [24:0]  tg;
        bit           hit, dmiss;
        logic [27:0]  exp_wb_addr;
        logic [127:0] exp_wb_data;
        logic [31:0]  exp_rd;
        int           exp_stalls;
        int           wait_cnt;
        int           n_wb;
        idx = a[4:2];
        tg  = a[29:5];
        hit   = mv[idx] && (mt[idx] == tg);
        dmiss = !hit && mv[idx] && md[idx];
        exp_wb_addr = {mt[idx], idx};
        exp_wb_data = ref_block({mt[idx], idx});
        exp_rd      = wr ? 32'h0 : ref_word(a);
        exp_stalls  = hit ? 0 : (1 + lat + (dmiss ? lat : 0));

        proc_read  = !wr;
        proc_write = wr;
        proc_addr  = a;
        proc_wdata = wd;
        stalls   = 0;
        wait_cnt = 0;
        n_wb     = 0;
        rd       = '0;
        forever begin
            @(negedge Clk);
            mem_ready = 1'b0;
            if (!proc_stall) begin
                rd = proc_rdata;
                break;
            end
            stalls++;
            if (stalls > 100) begin
                chk("timeout", 1'b1, 1'b0);
                break;
            end
            if (mem_read || mem_write) begin
                wait_cnt++;
                if (wait_cnt >= lat) begin
                    wait_cnt  = 0;
                    mem_ready = 1'b1;
                    chk("rd_wr_excl", mem_read & mem_write, 1'b0);
                    if (mem_write) begin
                        n_wb++;
                        chk("wb_addr", mem_addr, exp_wb_addr);
                        chk("wb_data", mem_wdata, exp_wb_data);
                        backing[mem_addr] = mem_wdata;
                    end else begin
                        chk("alloc_addr", mem_addr, a[29:2]);
                        mem_rdata = mem_block(mem_addr);
                    end
                end
            end
        end
        chk("stalls", stalls, exp_stalls);
        chk("wb_count", n_wb, dmiss ? 1 : 0);
        chk(wr ? "wr_rdata_zero" : "rdata", rd, exp_rd);

        if (!hit) begin
            mv[idx] = 1'b1;
            md[idx] = 1'b0;
            mt[idx] = tg;
        end
        if (wr) begin
            md[idx]   = 1'b1;
            ref_mem[a] = wd;
        end
        @(posedge Clk);
        #1;
        proc_read  = 1'b0;
        proc_write = 1'b0;
        mem_ready  = 1'b0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            if (mv[i] && md[i]) begin
                for (int o = 0; o < 4; o++) begin
                    logic [127:0] blk;
                    blk = mem_block({mt[i], 3'(i)});
                    ref_mem[{mt[i], 3'(i), 2'(o)}] = blk[o*32 +: 32];
                end
            end
            mv[i] = 1'b0;
            md[i] = 1'b0;
        end
    endtask

    logic [31:0] rd;
    int          st;

    initial begin
        rst_n      = 1'b0;
        proc_read  = 1'b0;
        proc_write = 1'b0;
        proc_addr  = '0;
        proc_wdata = '0;
        mem_rdata  = '0;
        mem_ready  = 1'b0;
        for (int i = 0; i < 8; i++) begin
            mv[i] = 1'b0;
            md[i] = 1'b0;
            mt[i] = '0;
        end
        backing[28'h4] = {32'd4, 32'd3, 32'd2, 32'd1};
        for (int o = 0; o < 4; o++) ref_mem[30'h10 + 30'(o)] = 32'(o + 1);

        repeat (2) @(negedge Clk);
        chk("rst_stall", proc_stall, 1'b0);
        chk("rst_mem_read", mem_read, 1'b0);
        chk("rst_mem_write", mem_write, 1'b0);
        rst_n = 1'b1;
        @(negedge Clk);
        chk("idle_rdata", proc_rdata, 32'h0);
        chk("idle_mem_addr", mem_addr, 28'h0);
        chk("idle_mem_wdata", mem_wdata, 128'h0);
        @(posedge Clk);
        #1;

        do_req(1'b0, 30'h10, 32'h0, 3, rd, st);
        chk("t1_rdata", rd, 32'd1);
        chk("t1_stalls", st, 4);
        do_req(1'b0, 30'h11, 32'h0, 3, rd, st);
        chk("t2_rdata", rd, 32'd2);
        chk("t2_stalls", st, 0);
        do_req(1'b1, 30'h12, 32'hDEADBEEF, 3, rd, st);
        chk("t3_wr_stalls", st, 0);
        do_req(1'b0, 30'h12, 32'h0, 3, rd, st);
        chk("t3_rdata", rd, 32'hDEADBEEF);
        chk("t3_rd_stalls", st, 0);
        do_req(1'b0, 30'h50, 32'h0, 2, rd, st);
        chk("t4_stalls", st, 5);
        chk("t4_backing", backing[28'h4], {32'd4, 32'hDEADBEEF, 32'd2, 32'd1});
        do_req(1'b1, 30'h3, 32'h1234_5678, 2, rd, st);
        chk("t5_stalls", st, 3);
        do_req(1'b0, 30'h3, 32'h0, 2, rd, st);
        chk("t5_rdata", rd, 32'h1234_5678);

        // Reset while ALLOCATE is waiting on the memory.
        proc_read = 1'b1;
        proc_addr = 30'h2A;
        repeat (3) @(negedge Clk);
        chk("t6_mem_read_before", mem_read, 1'b1);
        rst_n     = 1'b0;
        proc_read = 1'b0;
        #1;
        chk("t6_mem_read", mem_read, 1'b0);
        chk("t6_mem_write", mem_write, 1'b0);
        chk("t6_stall", proc_stall, 1'b0);
        @(negedge Clk);
        rst_n = 1'b1;
        model_reset();
        @(posedge Clk);
        #1;
        do_req(1'b0, 30'h3, 32'h0, 2, rd, st);
        chk("t6_miss_after_rst", st, 3);
        do_req(1'b0, 30'h2A, 32'h0, 1, rd, st);
        chk("t6_refetch_stalls", st, 2);

        for (int n = 0; n < 200; n++) begin
            bit          wr;
            logic [29:0] a;
            wr = 1'($urandom_range(0, 1));
            a  = 30'(($urandom_range(0, 3) << 5) | $urandom_range(0, 31));
            do_req(wr, a, $urandom, $urandom_range(1, 4), rd, st);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
